servo_pwm_gen: RTL and testbench
================================

# servo_pwm_gen

Servo PWM frame generator; consumes the registered pulse-width word held in the N-bit width register and produces the servo control waveform. Runs a fixed-length frame counter and emits one high pulse per frame whose length in clock cycles equals the active width. New widths are double-buffered and applied only at a frame boundary, so the output never carries a truncated or runt pulse.

## Interface
- BITS, 23: width of the pulse-width word and frame counter.
- PERIOD, 1000000: frame length in clk cycles (20 ms at 50 MHz); must be < 2^BITS.
- MIN_WIDTH, 50000: lower clamp, in cycles (1 ms).
- MAX_WIDTH, 100000: upper clamp, in cycles (2 ms); MIN_WIDTH ≤ MAX_WIDTH < PERIOD.

- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  run request; level-sensitive.
- load  input  1  single-cycle strobe; `width_in` is valid this cycle.
- width_in  input  BITS  requested pulse width in cycles, from the width register output.
- pwm  output  1  servo control signal, registered.
- frame_start  output  1  one-cycle pulse in the first cycle of every frame.
- update  output  1  one-cycle pulse, coincident with `frame_start`, when a newly loaded width takes effect.

## Operation
- Registers: `pending` (BITS), `pending_valid`, `active` (BITS), `cnt` (BITS), state.
- States: IDLE, RUN.
  - IDLE: `cnt`=0, `pwm`=0, `frame_start`=0. If `enable`=1, go to RUN; the first RUN cycle is frame cycle 0.
  - RUN: `cnt` counts 0..PERIOD-1, then wraps to 0. At the wrap edge, if `enable`=0, go to IDLE; otherwise start the next frame. Dropping `enable` mid-frame always completes the current frame.
- Load capture (any state): when `load`=1, `pending` ← processed `width_in` and `pending_valid` ← 1. A later load before the boundary overwrites the earlier one; last write wins.
- Frame boundary (entering frame cycle 0 from IDLE or from a wrap):
  - If `load`=1 on that same edge, `active` takes the processed `width_in` directly.
  - Otherwise, if `pending_valid`, `active` ← `pending`.
  - In either case, `pending_valid` clears and `update` asserts in frame cycle 0.
- Output: during RUN, `pwm`=1 exactly when `cnt` < `active`. The pulse is `active` cycles long and starts in frame cycle 0.
- Comparisons are unsigned at BITS width, with no overflow because PERIOD < 2^BITS.
- Reset (asynchronous, any time, including mid-frame):
  - state=IDLE; `cnt`, `active`, `pending` = 0; `pending_valid`=0.
  - `pwm`, `frame_start`, `update` = 0.
  - Outputs drop immediately, without waiting for a clock edge.
  - With `active`=0 after reset, frames are emitted with no pulse until the first load.

## Timing
- Frame length is exactly PERIOD cycles; `frame_start` repeats every PERIOD cycles while enabled.
- Enable latency: `enable` sampled high in IDLE at edge k, then `frame_start`=1 and `pwm` rises in cycle k+1 (if `active`>0).
- Load-to-effect: a width takes effect at the next frame boundary, 1 to PERIOD cycles later. A load coincident with the boundary edge takes effect in that frame.
- Boundary cases:
  - `active`=0: `pwm` stays low for the whole frame.
  - `active`=PERIOD (no-clamp build only): `pwm` stays high for the whole frame.
  - `active`>PERIOD is treated as PERIOD.

## Configuration
- `SERVO_PWM_CLAMP_EN` defined: processed width = min(max(`width_in`, MIN_WIDTH), MAX_WIDTH). A value of 0 loads MIN_WIDTH; the reset value of `active` remains 0.
- `SERVO_PWM_CLAMP_EN` undefined: processed width = min(`width_in`, PERIOD), with no lower clamp.

## Test plan
Use PERIOD=100, MIN_WIDTH=5, MAX_WIDTH=10, BITS=8, with the clamp enabled unless stated.
- Reset, then `enable`=1 with no load: `frame_start` every 100 cycles; `pwm`=0 throughout; `update` never asserts.
- Load 7 mid-frame: current frame unchanged. Next frame: `update`=1 and `frame_start`=1 in cycle 0, `pwm` high for exactly cycles 0–6, low for 93.
- Clamp:
  - load 2 → 5-cycle pulse; load 200 → 10-cycle pulse.
  - No-clamp build: load 2 → 2 cycles; load 0 → no pulse; load 150 → `pwm` high all 100 cycles.
- Load 8 at frame cycle 50, then 6 at cycle 80: next frame pulse is 6 cycles. A load of 9 on the wrap edge applies 9 in the frame starting at that edge.
- Drop `enable` at frame cycle 3 with `active`=8: pulse completes its 8 cycles, frame runs to cycle 99, then IDLE with `pwm`=0 and no further `frame_start`.
- Assert `reset` low at frame cycle 4 during a pulse: `pwm` drops without a clock edge, all outputs are 0, and `active` is 0 after release.

Source files
------------

// File: rtl/servo_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_gen
//  Brief    : Servo PWM frame generator. A fixed PERIOD-cycle frame counter
//             emits one high pulse per frame whose length equals the active
//             width. Loaded widths are double-buffered and swapped in only at
//             a frame boundary, so a pulse is never truncated.
//  Options  : SERVO_PWM_CLAMP_EN - when defined, loaded widths are clamped to
//             [MIN_WIDTH, MAX_WIDTH]; otherwise they are limited to PERIOD.
//  Revision : 1.0 - initial release
// ============================================================================
module servo_pwm_gen #(
    parameter int BITS      = 23,
    parameter int PERIOD    = 1000000,
    parameter int MIN_WIDTH = 50000,
    parameter int MAX_WIDTH = 100000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            load,
    input  logic [BITS-1:0] width_in,
    output logic            pwm,
    output logic            frame_start,
    output logic            update
);

    localparam logic [BITS-1:0] c_last   = BITS'(PERIOD - 1);
    localparam bit              c_cfg_ok = (MIN_WIDTH <= MAX_WIDTH) &&
                                           (MAX_WIDTH < PERIOD) &&
                                           (PERIOD < (2 ** BITS));

    // Refuse to elaborate with a frame that cannot fit the counter or clamps
    // that fall outside the frame.
    if (!c_cfg_ok) begin : g_cfg_bad
        $error("servo_pwm_gen: need MIN_WIDTH <= MAX_WIDTH < PERIOD < 2**BITS");
    end

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [BITS-1:0] r_cnt;
    logic [BITS-1:0] w_cnt_nxt;
    logic [BITS-1:0] r_active;
    logic [BITS-1:0] w_active_nxt;
    logic [BITS-1:0] r_pending;
    logic            r_pending_valid;
    logic [BITS-1:0] w_proc;
    logic            w_boundary;
    logic            w_update_nxt;
    logic            w_pwm_nxt;
    logic            r_pwm;
    logic            r_frame_start;
    logic            r_update;

`ifdef SERVO_PWM_CLAMP_EN
    localparam logic [BITS-1:0] c_min = BITS'(MIN_WIDTH);
    localparam logic [BITS-1:0] c_max = BITS'(MAX_WIDTH);

    // Clamp the requested width into the legal servo range.
    always_comb begin
        w_proc = width_in;
        if (width_in < c_min) begin
            w_proc = c_min;
        end else if (width_in > c_max) begin
            w_proc = c_max;
        end
    end
`else
    localparam logic [BITS-1:0] c_period = BITS'(PERIOD);

    // Limit the requested width to one full frame; no lower bound.
    always_comb begin
        w_proc = width_in;
        if (width_in > c_period) begin
            w_proc = c_period;
        end
    end
`endif

    // Next-state, frame counter and boundary detection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_boundary  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = S_RUN;
                    w_boundary  = 1'b1;
                end
            end
            S_RUN: begin
                if (r_cnt == c_last) begin
                    w_cnt_nxt = '0;
                    if (enable) begin
                        w_boundary = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Width swap at the boundary; a same-edge load bypasses the pending slot.
    always_comb begin
        w_active_nxt = r_active;
        w_update_nxt = 1'b0;
        if (w_boundary) begin
            if (load) begin
                w_active_nxt = w_proc;
                w_update_nxt = 1'b1;
            end else if (r_pending_valid) begin
                w_active_nxt = r_pending;
                w_update_nxt = 1'b1;
            end
        end
        w_pwm_nxt = (w_state_nxt == S_RUN) && (w_cnt_nxt < w_active_nxt);
    end

    // State, counter, width buffers and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_active        <= '0;
            r_pending       <= '0;
            r_pending_valid <= 1'b0;
            r_pwm           <= 1'b0;
            r_frame_start   <= 1'b0;
            r_update        <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_active <= w_active_nxt;
            if (load) begin
                r_pending <= w_proc;
            end
            if (w_boundary) begin
                r_pending_valid <= 1'b0;
            end else if (load) begin
                r_pending_valid <= 1'b1;
            end
            r_pwm         <= w_pwm_nxt;
            r_frame_start <= w_boundary;
            r_update      <= w_update_nxt;
        end
    end

    assign pwm         = r_pwm;
    assign frame_start = r_frame_start;
    assign update      = r_update;

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servo_pwm_gen
//  Brief    : Scoreboard bench for servo_pwm_gen. The driver predicts each
//             frame (start time, update flag, pulse width) from frame-level
//             rules and queues it; a monitor pops one entry per frame_start
//             and checks the pulse shape cycle by cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_servo_pwm_gen;

    localparam int BITS   = 8;
    localparam int PERIOD = 100;
    localparam int MIN_W  = 5;
    localparam int MAX_W  = 10;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b0;
    logic            load = 1'b0;
    logic [BITS-1:0] width_in = '0;
    logic            pwm;
    logic            frame_start;
    logic            update;

    servo_pwm_gen #(
        .BITS      (BITS),
        .PERIOD    (PERIOD),
        .MIN_WIDTH (MIN_W),
        .MAX_WIDTH (MAX_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .width_in    (width_in),
        .pwm         (pwm),
        .frame_start (frame_start),
        .update      (update)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Count of rising edges seen; frames are predicted against it.
    int tick = 0;
    always @(posedge clk) tick = tick + 1;

    typedef struct {
        int t;
        bit upd;
        int w;
    } exp_t;
    exp_t exp_q[$];

    // Frame-level reference model.
    bit m_run = 0;
    int m_pos = 0;
    int m_act = 0;
    int m_pend = 0;
    bit m_pv = 0;

    function automatic int proc(input int w);
`ifdef SERVO_PWM_CLAMP_EN
        if (w < MIN_W) return MIN_W;
        if (w > MAX_W) return MAX_W;
        return w;
`else
        return (w > PERIOD) ? PERIOD : w;
`endif
    endfunction

    // Apply inputs for one clock edge and predict that edge's effect.
    task automatic step(input bit en, input bit ld, input int w);
        bit   boundary;
        exp_t e;
        enable   = en;
        load     = ld;
        width_in = w[BITS-1:0];
        boundary = 0;
        if (!m_run) begin
            if (en) begin
                boundary = 1;
                m_run    = 1;
                m_pos    = 0;
            end
        end else if (m_pos == PERIOD - 1) begin
            if (en) begin
                boundary = 1;
                m_pos    = 0;
            end else begin
                m_run = 0;
            end
        end else begin
            m_pos++;
        end
        if (boundary) begin
            e.upd = 1;
            if (ld) begin
                m_act = proc(w);
            end else if (m_pv) begin
                m_act = m_pend;
            end else begin
                e.upd = 0;
            end
            m_pv = 0;
            e.t  = tick + 1;
            e.w  = m_act;
            exp_q.push_back(e);
        end else if (ld) begin
            m_pend = proc(w);
            m_pv   = 1;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic run(input int n, input bit en);
        repeat (n) step(en, 0, 0);
    endtask

    // Keep running until the current cycle is frame position pos.
    task automatic run_to(input int pos);
        for (int i = 0; i < 3 * PERIOD; i++) begin
            if (m_run && m_pos == pos) return;
            step(1, 0, 0);
        end
    endtask

    // Monitor: one scoreboard entry per frame_start, then per-cycle shape.
    bit   mi_frame = 0;
    int   mcyc = 0;
    int   mhigh = 0;
    int   mw = 0;
    bit   mbad = 0;
    exp_t me;

    always @(negedge clk) begin
        if (!reset) begin
            mi_frame = 0;
        end else begin
            if (frame_start) begin
                if (mi_frame) chk("frame_len", mcyc, PERIOD);
                mi_frame = 0;
                chk("frame_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    me = exp_q.pop_front();
                    chk("frame_start_time", tick, me.t);
                    chk("update", int'(update), int'(me.upd));
                    mi_frame = 1;
                    mcyc     = 0;
                    mhigh    = 0;
                    mbad     = 0;
                    mw       = me.w;
                end
            end else begin
                chk("update_outside_frame_start", int'(update), 0);
            end
            if (mi_frame) begin
                if (pwm !== (mcyc < mw)) mbad = 1;
                mhigh += int'(pwm);
                mcyc++;
                if (mcyc == PERIOD) begin
                    chk("pulse_len", mhigh, mw);
                    chk("pulse_shape_bad", int'(mbad), 0);
                    mi_frame = 0;
                end
            end else begin
                chk("pwm_idle_low", int'(pwm), 0);
            end
        end
    end

    bit en_r;

    initial begin
        #1 reset = 1'b0;
        #1;
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_frame_start", int'(frame_start), 0);
        chk("reset_update", int'(update), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Enabled with no load: empty frames, no update.
        run(250, 1);

        // Mid-frame load takes effect next frame.
        run_to(50);
        step(1, 1, 7);
        run_to(30);
        step(1, 1, 2);
        run_to(30);
        step(1, 1, 200);
        run_to(30);

        // Last write wins; load on the wrap edge applies immediately.
        run_to(50);
        step(1, 1, 8);
        run_to(80);
        step(1, 1, 6);
        run_to(99);
        step(1, 1, 9);
        run_to(20);
        step(1, 1, 0);
        run_to(20);
        step(1, 1, 150);
        run_to(20);

        // Drop enable mid-pulse with an 8-cycle width.
        step(1, 1, 8);
        run_to(0);
        run_to(3);
        run(150, 0);

        // Randomized enable/load traffic.
        en_r = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 249) == 0) en_r = !en_r;
            step(en_r, $urandom_range(0, 24) == 0, int'($urandom_range(0, 255)));
        end

        // Asynchronous reset in the middle of a pulse.
        step(1, 1, 8);
        run_to(0);
        run_to(4);
        #1;
        chk("pwm_before_reset", int'(pwm), 1);
        #1 reset = 1'b0;
        #1;
        chk("async_reset_pwm", int'(pwm), 0);
        chk("async_reset_frame_start", int'(frame_start), 0);
        chk("async_reset_update", int'(update), 0);
        exp_q.delete();
        m_run  = 0;
        m_act  = 0;
        m_pend = 0;
        m_pv   = 0;
        enable = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        // Active width is zero after reset: empty frames.
        run(250, 1);

        // Drain and confirm every predicted frame was seen.
        run(2 * PERIOD + 5, 0);
        chk("frames_left_in_queue", exp_q.size(), 0);
        chk("frame_left_open", int'(mi_frame), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
